branch_resolve: RTL and testbench

//  Consumer side of the cmp flag interface: holds the 4-bit flag word {N,Z,C,V} written back by cmp
//  and resolves conditional-branch requests against it.

---
 rtl/branch_resolve.sv | 137 +++++++++++++
 tb/tb_branch_resolve.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - resolves conditional branches against the cmp flag word
// Holds {N,Z,C,V}, tracks one outstanding compare and answers each branch over valid/ready.
module branch_resolve #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    flag_in,
  input  logic          flag_we,
  input  logic          cmp_issue,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [3:0]    br_cond,
  input  logic [AW-1:0] br_target,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_taken,
  output logic [AW-1:0] resp_target,
  output logic          resp_err,
  output logic [3:0]    flags_q,
  output logic          pending
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   wait_cnt, wait_cnt_n;
  logic [3:0]      cond_q, cond_n;
  logic [AW-1:0]   target_n;
  logic            taken_n, err_n;
  logic [3:0]      eff_flags;
  logic            reserved, resolvable;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0:    eval_cond = f[2];
      4'h1:    eval_cond = !f[2];
      4'h2:    eval_cond = f[3];
      4'h3:    eval_cond = !f[3];
      4'h4:    eval_cond = !f[3] && !f[2];
      4'h5:    eval_cond = f[3] || f[2];
      4'h6:    eval_cond = f[1];
      4'h7:    eval_cond = !f[1];
      4'h8:    eval_cond = f[0];
      4'h9:    eval_cond = !f[0];
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  assign eff_flags  = flag_we ? flag_in : flags_q;
  assign reserved   = (br_cond >= 4'hA) && (br_cond <= 4'hD);
  // AL/NV/reserved never depend on flags, so they need not wait for the compare
  assign resolvable = !pending || flag_we || reserved || (br_cond == 4'hE) || (br_cond == 4'hF);
  assign br_ready   = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0;
      pending <= 1'b0;
    end else begin
      if (flag_we)
        flags_q <= flag_in;
      if (cmp_issue && !flag_we)
        pending <= 1'b1;
      else if (flag_we && !cmp_issue)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cond_q      <= 4'h0;
      resp_target <= '0;
      resp_taken  <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      cond_q      <= cond_n;
      resp_target <= target_n;
      resp_taken  <= taken_n;
      resp_err    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    cond_n     = cond_q;
    target_n   = resp_target;
    taken_n    = resp_taken;
    err_n      = resp_err;
    case (state)
      IDLE: begin
        if (br_valid) begin
          cond_n   = br_cond;
          target_n = br_target;
          if (resolvable) begin
            taken_n = eval_cond(br_cond, eff_flags);
            err_n   = reserved;
            state_n = RESP;
          end else begin
            wait_cnt_n = '0;
            state_n    = WAIT;
          end
        end
      end
      WAIT: begin
        // flags arriving on the timeout cycle still win
        if (flag_we) begin
          taken_n = eval_cond(cond_q, flag_in);
          err_n   = 1'b0;
          state_n = RESP;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          taken_n = 1'b0;
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve
// Stimulus pushes expected responses; a negedge monitor pops and compares on each handshake.
module tb_branch_resolve;

  localparam int AW      = 32;
  localparam int TIMEOUT = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    flag_in;
  logic          flag_we;
  logic          cmp_issue;
  logic          br_valid;
  logic          br_ready;
  logic [3:0]    br_cond;
  logic [AW-1:0] br_target;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_taken;
  logic [AW-1:0] resp_target;
  logic          resp_err;
  logic [3:0]    flags_q;
  logic          pending;

  typedef struct {
    logic          taken;
    logic          err;
    logic [AW-1:0] target;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  branch_resolve #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flag_in(flag_in), .flag_we(flag_we), .cmp_issue(cmp_issue),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_taken(resp_taken),
    .resp_target(resp_target), .resp_err(resp_err), .flags_q(flags_q), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'(1'b0));
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("resp_taken", 32'(resp_taken), 32'(e.taken));
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_target", resp_target, e.target);
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] t, input logic et, input logic ee,
                      input logic imm, input logic push);
    int n;
    exp_t e;
    n = 0;
    br_cond   = c;
    br_target = t;
    br_valid  = 1'b1;
    while (!br_ready && n < 50) begin
      tick();
      n++;
    end
    chk("br_ready_wait", 32'(br_ready), 32'(1'b1));
    if (push) begin
      e.taken  = et;
      e.err    = ee;
      e.target = t;
      expq.push_back(e);
    end
    tick();
    br_valid  = 1'b0;
    flag_we   = 1'b0;
    cmp_issue = 1'b0;
    chk("resp_latency", 32'(resp_valid), 32'(imm));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 32'(expq.size()), 32'd0);
  endtask

  task automatic load_flags(input logic [3:0] f);
    flag_in = f;
    flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
  endtask

  logic [3:0] single [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic       gt_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       le_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; flag_in = 4'h0; flag_we = 1'b0; cmp_issue = 1'b0;
    br_valid = 1'b0; br_cond = 4'h0; br_target = '0; resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(br_ready), 32'd1);
    chk("rst_taken", 32'(resp_taken), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_target", resp_target, 32'd0);

    // EQ against loaded Z
    load_flags(4'b0100);
    chk("flags_load", 32'(flags_q), 32'b0100);
    send(4'h0, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    // LT waits for outstanding compare
    cmp_issue = 1'b1; tick(); cmp_issue = 1'b0;
    chk("pending_set", 32'(pending), 32'd1);
    send(4'h2, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("wait_br_ready", 32'(br_ready), 32'd0);
    tick(); tick();
    chk("wait_no_resp", 32'(resp_valid), 32'd0);
    flag_in = 4'b1000; flag_we = 1'b1; tick(); flag_we = 1'b0;
    chk("wait_resolved", 32'(resp_valid), 32'd1);
    chk("pending_clr", 32'(pending), 32'd0);
    drain();

    // GE timeout
    cmp_issue = 1'b1; tick(); cmp_issue = 1'b0;
    send(4'h3, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("timeout_not_yet", 32'(resp_valid), 32'd0);
    tick();
    chk("timeout_resp", 32'(resp_valid), 32'd1);
    chk("timeout_pending", 32'(pending), 32'd1);
    drain();

    // GE with flags arriving on the timeout cycle
    send(4'h3, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("late_no_resp", 32'(resp_valid), 32'd0);
    flag_in = 4'b0000; flag_we = 1'b1; tick(); flag_we = 1'b0;
    chk("late_resp", 32'(resp_valid), 32'd1);
    drain();

    // reserved cond, then AL/NV while pending
    send(4'hB, 32'h1B0, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    cmp_issue = 1'b1; tick(); cmp_issue = 1'b0;
    send(4'hE, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    send(4'hF, 32'h204, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    send(4'hC, 32'h208, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // pending with flag_we on accept resolves immediately with flag_in
    flag_in = 4'b0100; flag_we = 1'b1;
    send(4'h1, 32'h20C, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    chk("accept_retire", 32'(pending), 32'd0);

    // response back-pressure
    resp_ready = 1'b0;
    send(4'h0, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_ready", 32'(br_ready), 32'd0);
      chk("stall_taken", 32'(resp_taken), 32'd1);
      chk("stall_target", resp_target, 32'h300);
    end
    resp_ready = 1'b1;
    drain();

    // reset while in WAIT discards the request
    cmp_issue = 1'b1; tick(); cmp_issue = 1'b0;
    send(4'h2, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rstw_valid", 32'(resp_valid), 32'd0);
    chk("rstw_ready", 32'(br_ready), 32'd1);
    chk("rstw_target", resp_target, 32'd0);
    chk("rstw_pending", 32'(pending), 32'd0);
    chk("rstw_flags", 32'(flags_q), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < TIMEOUT + 2; i++) tick();
    chk("rstw_no_resp", 32'(resp_valid), 32'd0);

    // simultaneous flag_we and cmp_issue
    flag_in = 4'h0; flag_we = 1'b1; cmp_issue = 1'b1; tick();
    chk("both_from0", 32'(pending), 32'd0);
    flag_we = 1'b0; tick();
    chk("issue_only", 32'(pending), 32'd1);
    flag_we = 1'b1; tick();
    chk("both_from1", 32'(pending), 32'd1);
    cmp_issue = 1'b0; tick(); flag_we = 1'b0;
    chk("we_only", 32'(pending), 32'd0);

    // GT / LE over each single flag bit
    for (int i = 0; i < 4; i++) begin
      load_flags(single[i]);
      send(4'h4, 32'h500 + 32'(i), gt_exp[i], 1'b0, 1'b1, 1'b1);
      drain();
      send(4'h5, 32'h600 + 32'(i), le_exp[i], 1'b0, 1'b1, 1'b1);
      drain();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
